execute_stage: RTL and testbench

- Y86-64 execute stage, directly downstream of the register file / decode logic.
- Consumes decoded `icode`/`ifun`, `valC`, and register read values `valA`/`valB` plus destination IDs `dstE`/`dstM`.
- Computes `valE` through the ALU, holds the architectural condition-code register (ZF/SF/OF), evaluates `Cnd` for jXX/cmovXX, and cancels `dstE` on a not-taken cmov.
- Results go into a registered E/M pipeline latch with stall and bubble control. The registered `dstE`/`valE` is what eventually returns to the register file write port.

---
 rtl/execute_stage.sv | 203 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, ALU, condition-code register,
// jXX/cmovXX condition evaluation with cmov destination cancel, and the
// registered E/M pipeline latch with stall and bubble control.
module execute_stage #(
    parameter int DATA_WID   = 64,
    parameter int ADDR_WID   = 4,
    parameter int STACK_STEP = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          e_icode,
    input  logic [3:0]          e_ifun,
    input  logic [DATA_WID-1:0] e_valC,
    input  logic [DATA_WID-1:0] e_valA,
    input  logic [DATA_WID-1:0] e_valB,
    input  logic [ADDR_WID-1:0] e_dstE,
    input  logic [ADDR_WID-1:0] e_dstM,
    input  logic                stall,
    input  logic                bubble,
    input  logic                mem_exc,
    output logic [3:0]          m_icode,
    output logic                m_Cnd,
    output logic [DATA_WID-1:0] m_valE,
    output logic [DATA_WID-1:0] m_valA,
    output logic [ADDR_WID-1:0] m_dstE,
    output logic [ADDR_WID-1:0] m_dstM,
    output logic [2:0]          cc
);

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [1:0] FN_ADD = 2'd0;
    localparam logic [1:0] FN_SUB = 2'd1;
    localparam logic [1:0] FN_AND = 2'd2;
    localparam logic [1:0] FN_XOR = 2'd3;

    localparam logic [DATA_WID-1:0] ZERO     = {DATA_WID{1'b0}};
    localparam logic [DATA_WID-1:0] POS_STEP = DATA_WID'(STACK_STEP);
    localparam logic [DATA_WID-1:0] NEG_STEP = ZERO - POS_STEP;
    localparam logic [ADDR_WID-1:0] REG_NONE = {ADDR_WID{1'b1}};
    localparam logic [2:0]          CC_RST   = 3'b100;

    logic [DATA_WID-1:0] alu_a_s, alu_b_s, alu_res_s;
    logic [1:0]          alu_fn_s;
    logic                zf_s, sf_s, of_s;
    logic                cond_s, cnd_s;
    logic                cc_zf_s, cc_sf_s, cc_of_s;

    logic [3:0]          icode_q, icode_d;
    logic                cnd_q, cnd_d;
    logic [DATA_WID-1:0] vale_q, vale_d;
    logic [DATA_WID-1:0] vala_q, vala_d;
    logic [ADDR_WID-1:0] dste_q, dste_d;
    logic [ADDR_WID-1:0] dstm_q, dstm_d;
    logic [2:0]          cc_q, cc_d;

    assign cc_zf_s = cc_q[2];
    assign cc_sf_s = cc_q[1];
    assign cc_of_s = cc_q[0];

    // Select ALU operands and function from the instruction code.
    always_comb begin
        alu_a_s  = ZERO;
        alu_b_s  = ZERO;
        alu_fn_s = FN_ADD;
        case (e_icode)
            I_RRMOV:          alu_a_s = e_valA;
            I_IRMOV:          alu_a_s = e_valC;
            I_RMMOV, I_MRMOV: begin alu_a_s = e_valC;   alu_b_s = e_valB; end
            I_OPQ:            begin alu_a_s = e_valA;   alu_b_s = e_valB; end
            I_CALL, I_PUSH:   begin alu_a_s = NEG_STEP; alu_b_s = e_valB; end
            I_RET, I_POP:     begin alu_a_s = POS_STEP; alu_b_s = e_valB; end
            default:          alu_a_s = ZERO;
        endcase
        if (e_icode == I_OPQ) begin
            case (e_ifun)
                4'h0:    alu_fn_s = FN_ADD;
                4'h1:    alu_fn_s = FN_SUB;
                4'h2:    alu_fn_s = FN_AND;
                4'h3:    alu_fn_s = FN_XOR;
                default: alu_fn_s = FN_ADD;
            endcase
        end else begin
            alu_fn_s = FN_ADD;
        end
    end

    // ALU result and the flags it would produce.
    always_comb begin
        alu_res_s = ZERO;
        of_s      = 1'b0;
        case (alu_fn_s)
            FN_ADD: begin
                alu_res_s = alu_b_s + alu_a_s;
                of_s = (alu_a_s[DATA_WID-1] == alu_b_s[DATA_WID-1]) &&
                       (alu_res_s[DATA_WID-1] != alu_a_s[DATA_WID-1]);
            end
            FN_SUB: begin
                alu_res_s = alu_b_s - alu_a_s;
                of_s = (alu_b_s[DATA_WID-1] != alu_a_s[DATA_WID-1]) &&
                       (alu_res_s[DATA_WID-1] != alu_b_s[DATA_WID-1]);
            end
            FN_AND:  alu_res_s = alu_b_s & alu_a_s;
            FN_XOR:  alu_res_s = alu_b_s ^ alu_a_s;
            default: alu_res_s = ZERO;
        endcase
        zf_s = (alu_res_s == ZERO);
        sf_s = alu_res_s[DATA_WID-1];
    end

    // Branch/cmov condition from the CC register as it stood before this edge.
    always_comb begin
        cond_s = 1'b0;
        case (e_ifun)
            4'h0:    cond_s = 1'b1;
            4'h1:    cond_s = (cc_sf_s ^ cc_of_s) | cc_zf_s;
            4'h2:    cond_s = cc_sf_s ^ cc_of_s;
            4'h3:    cond_s = cc_zf_s;
            4'h4:    cond_s = ~cc_zf_s;
            4'h5:    cond_s = ~(cc_sf_s ^ cc_of_s);
            4'h6:    cond_s = ~(cc_sf_s ^ cc_of_s) & ~cc_zf_s;
            default: cond_s = 1'b0;
        endcase
        if ((e_icode == I_JXX) || (e_icode == I_RRMOV)) begin
            cnd_s = cond_s;
        end else begin
            cnd_s = 1'b1;
        end
    end

    // Next-state for the E/M latch and CC: stall holds, bubble inserts a NOP.
    always_comb begin
        icode_d = icode_q;
        cnd_d   = cnd_q;
        vale_d  = vale_q;
        vala_d  = vala_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        cc_d    = cc_q;
        if (stall) begin
            cc_d = cc_q;
        end else if (bubble) begin
            icode_d = I_NOP;
            cnd_d   = 1'b0;
            vale_d  = ZERO;
            vala_d  = ZERO;
            dste_d  = REG_NONE;
            dstm_d  = REG_NONE;
        end else begin
            icode_d = e_icode;
            cnd_d   = cnd_s;
            vale_d  = alu_res_s;
            vala_d  = e_valA;
            dste_d  = ((e_icode == I_RRMOV) && !cnd_s) ? REG_NONE : e_dstE;
            dstm_d  = e_dstM;
            if ((e_icode == I_OPQ) && !mem_exc) begin
                cc_d = {zf_s, sf_s, of_s};
            end else begin
                cc_d = cc_q;
            end
        end
    end

    // E/M latch and CC register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            icode_q <= I_NOP;
            cnd_q   <= 1'b0;
            vale_q  <= ZERO;
            vala_q  <= ZERO;
            dste_q  <= REG_NONE;
            dstm_q  <= REG_NONE;
            cc_q    <= CC_RST;
        end else begin
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
            cc_q    <= cc_d;
        end
    end

    assign m_icode = icode_q;
    assign m_Cnd   = cnd_q;
    assign m_valE  = vale_q;
    assign m_valA  = vala_q;
    assign m_dstE  = dste_q;
    assign m_dstM  = dstm_q;
    assign cc      = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the execute stage.
module tb_execute_stage;

    logic        CLK = 1'b0;
    logic        RST, stall, bubble, mem_exc;
    logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM;
    logic [63:0] e_valC, e_valA, e_valB;
    logic [3:0]  m_icode, m_dstE, m_dstM;
    logic        m_Cnd;
    logic [63:0] m_valE, m_valA;
    logic [2:0]  cc;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // model state
    logic [3:0]  x_icode, x_dstE, x_dstM;
    logic        x_cnd;
    logic [63:0] x_valE, x_valA;
    logic [2:0]  x_cc;

    always #5 CLK = ~CLK;

    execute_stage dut (
        .CLK(CLK), .RST(RST),
        .e_icode(e_icode), .e_ifun(e_ifun), .e_valC(e_valC),
        .e_valA(e_valA), .e_valB(e_valB), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .stall(stall), .bubble(bubble), .mem_exc(mem_exc),
        .m_icode(m_icode), .m_Cnd(m_Cnd), .m_valE(m_valE), .m_valA(m_valA),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .cc(cc)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic set_in(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] de, input logic [3:0] dm);
        e_icode = ic; e_ifun = fn; e_valC = c; e_valA = a; e_valB = b;
        e_dstE = de; e_dstM = dm;
    endtask

    // What the stage should hold after the coming clock edge.
    task automatic model_edge();
        longint a, b, r;
        bit zf, sf, of, cond, take;
        int op;
        if (RST) begin
            x_icode = 4'h1; x_cnd = 1'b0; x_valE = 64'h0; x_valA = 64'h0;
            x_dstE = 4'hF; x_dstM = 4'hF; x_cc = 3'b100;
            return;
        end
        if (stall) return;
        if (bubble) begin
            x_icode = 4'h1; x_cnd = 1'b0; x_valE = 64'h0; x_valA = 64'h0;
            x_dstE = 4'hF; x_dstM = 4'hF;
            return;
        end
        zf = x_cc[2]; sf = x_cc[1]; of = x_cc[0];
        case (e_ifun)
            4'h0: cond = 1'b1;
            4'h1: cond = (sf != of) || zf;
            4'h2: cond = (sf != of);
            4'h3: cond = zf;
            4'h4: cond = !zf;
            4'h5: cond = (sf == of);
            4'h6: cond = (sf == of) && !zf;
            default: cond = 1'b0;
        endcase
        a = 0; b = 0; op = 0;
        case (e_icode)
            4'h2: a = e_valA;
            4'h3: a = e_valC;
            4'h4, 4'h5: begin a = e_valC; b = e_valB; end
            4'h6: begin a = e_valA; b = e_valB; op = int'(e_ifun); end
            4'h8, 4'hA: begin a = -8; b = e_valB; end
            4'h9, 4'hB: begin a = 8; b = e_valB; end
            default: ;
        endcase
        case (op)
            1: r = b - a;
            2: r = b & a;
            3: r = b ^ a;
            default: r = b + a;
        endcase
        take = (e_icode == 4'h7 || e_icode == 4'h2) ? cond : 1'b1;
        x_icode = e_icode;
        x_cnd   = take;
        x_valE  = r;
        x_valA  = e_valA;
        x_dstE  = (e_icode == 4'h2 && !take) ? 4'hF : e_dstE;
        x_dstM  = e_dstM;
        if (e_icode == 4'h6 && !mem_exc) begin
            zf = (r == 0);
            sf = (r < 0);
            if (op == 1)      of = ((a < 0) != (b < 0)) && ((r < 0) != (b < 0));
            else if (op == 2 || op == 3) of = 1'b0;
            else              of = ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
            x_cc = {zf, sf, of};
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
        check_val("m_icode", {60'h0, m_icode}, {60'h0, x_icode});
        check_val("m_Cnd",   {63'h0, m_Cnd},   {63'h0, x_cnd});
        check_val("m_valE",  m_valE, x_valE);
        check_val("m_valA",  m_valA, x_valA);
        check_val("m_dstE",  {60'h0, m_dstE},  {60'h0, x_dstE});
        check_val("m_dstM",  {60'h0, m_dstM},  {60'h0, x_dstM});
        check_val("cc",      {61'h0, cc},      {61'h0, x_cc});
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(($urandom_range(0, 15)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        RST = 1'b1; stall = 1'b0; bubble = 1'b0; mem_exc = 1'b0;
        set_in(4'h6, 4'h0, 64'h5, 64'h9, 64'h3, 4'h2, 4'h3);
        // 1: reset for two cycles
        cycle();
        cycle();
        check_val("rst_icode", {60'h0, m_icode}, 64'h1);
        check_val("rst_cnd",   {63'h0, m_Cnd},   64'h0);
        check_val("rst_dstE",  {60'h0, m_dstE},  64'hF);
        check_val("rst_cc",    {61'h0, cc},      64'h4);
        RST = 1'b0;
        set_in(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        cycle();
        check_val("nop_valE", m_valE, 64'h0);
        // 2: sub giving zero, then signed-overflowing add
        set_in(4'h6, 4'h1, 64'h0, 64'h5, 64'h5, 4'h0, 4'hF);
        cycle();
        check_val("sub0_valE", m_valE, 64'h0);
        check_val("sub0_dstE", {60'h0, m_dstE}, 64'h0);
        check_val("sub0_cc",   {61'h0, cc}, 64'h4);
        set_in(4'h6, 4'h0, 64'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF);
        cycle();
        check_val("addov_valE", m_valE, 64'h8000_0000_0000_0000);
        check_val("addov_cc",   {61'h0, cc}, 64'h3);
        // 3: cmov with cc=011 (ZF=0, SF=1, OF=1)
        set_in(4'h2, 4'h3, 64'h0, 64'h55, 64'h0, 4'h1, 4'hF);
        cycle();
        check_val("cmove_cnd",  {63'h0, m_Cnd}, 64'h0);
        check_val("cmove_dstE", {60'h0, m_dstE}, 64'hF);
        set_in(4'h2, 4'h2, 64'h0, 64'h55, 64'h0, 4'h1, 4'hF);
        cycle();
        check_val("cmovl_cnd",  {63'h0, m_Cnd}, 64'h0);
        set_in(4'h2, 4'h5, 64'h0, 64'h55, 64'h0, 4'h1, 4'hF);
        cycle();
        check_val("cmovge_cnd",  {63'h0, m_Cnd}, 64'h1);
        check_val("cmovge_dstE", {60'h0, m_dstE}, 64'h1);
        check_val("cmovge_valE", m_valE, 64'h55);
        // 4: stack adjust and immediate move
        set_in(4'hA, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4, 4'hF);
        cycle();
        check_val("push_valE", m_valE, 64'hF8);
        set_in(4'hB, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4, 4'h7);
        cycle();
        check_val("pop_valE", m_valE, 64'h108);
        set_in(4'h3, 4'h0, 64'h3, 64'h0, 64'h0, 4'h5, 4'hF);
        cycle();
        check_val("irmov_valE", m_valE, 64'h3);
        check_val("irmov_cc",   {61'h0, cc}, 64'h3);
        // 5: stall freezes, release updates once; bubble inserts NOP
        set_in(4'h6, 4'h3, 64'h0, 64'hFF, 64'hF0, 4'h3, 4'hF);
        stall = 1'b1;
        repeat (3) cycle();
        check_val("stall_valE", m_valE, 64'h3);
        check_val("stall_cc",   {61'h0, cc}, 64'h3);
        stall = 1'b0;
        cycle();
        check_val("xor_valE", m_valE, 64'h0F);
        check_val("xor_cc",   {61'h0, cc}, 64'h0);
        set_in(4'h6, 4'h1, 64'h0, 64'h5, 64'h5, 4'h3, 4'h2);
        bubble = 1'b1;
        cycle();
        check_val("bub_icode", {60'h0, m_icode}, 64'h1);
        check_val("bub_dstE",  {60'h0, m_dstE}, 64'hF);
        check_val("bub_cc",    {61'h0, cc}, 64'h0);
        bubble = 1'b0;
        // 6: mem_exc blocks CC; reset overrides stall
        set_in(4'h6, 4'h1, 64'h0, 64'h2, 64'h1, 4'h5, 4'hF);
        mem_exc = 1'b1;
        cycle();
        check_val("exc_valE", m_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("exc_cc",   {61'h0, cc}, 64'h0);
        mem_exc = 1'b0;
        stall = 1'b1; RST = 1'b1;
        cycle();
        check_val("rststall_valE", m_valE, 64'h0);
        check_val("rststall_cc",   {61'h0, cc}, 64'h4);
        stall = 1'b0; RST = 1'b0;
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            RST     = ($urandom_range(0, 49) == 0);
            stall   = ($urandom_range(0, 7) == 0);
            bubble  = ($urandom_range(0, 7) == 0);
            mem_exc = ($urandom_range(0, 5) == 0);
            e_icode = 4'($urandom_range(0, 15));
            e_ifun  = (e_icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            e_valC  = rnd_val();
            e_valA  = rnd_val();
            e_valB  = ($urandom_range(0, 4) == 0) ? e_valA : rnd_val();
            e_dstE  = 4'($urandom_range(0, 15));
            e_dstM  = 4'($urandom_range(0, 15));
            cycle();
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
